// File: rtl/arch_defs_pkg.sv
// Shared SAP-2 architecture definitions: opcodes, ALU operations, the control word
// and the sequencer state encoding.
package arch_defs_pkg;

    localparam int unsigned OPCODE_WIDTH = 4;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OpNop  = 4'h0,
        OpLda  = 4'h1,
        OpAdd  = 4'h2,
        OpSub  = 4'h3,
        OpSta  = 4'h4,
        OpLdi  = 4'h5,
        OpJmp  = 4'h6,
        OpJc   = 4'h7,
        OpJz   = 4'h8,
        OpJn   = 4'h9,
        OpOuta = 4'hE,
        OpHlt  = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2
    } alu_op_t;

    typedef struct packed {
        logic    oe_pc;
        logic    oe_ram;
        logic    oe_ir;
        logic    oe_a;
        logic    oe_alu;
        logic    load_mar;
        logic    load_ir;
        logic    load_a;
        logic    load_b;
        logic    load_o;
        logic    load_pc;
        logic    load_flags;
        logic    pc_inc;
        logic    ram_we;
        logic    halt;
        alu_op_t alu_op;
    } control_word_t;

    typedef enum logic {
        StRun  = 1'b0,
        StHalt = 1'b1
    } seq_state_e;

endpackage

// File: rtl/control_decoder.sv
// Combinational microcode decoder: maps (microstep, opcode, flags) to one control word.
module control_decoder
    import arch_defs_pkg::*;
#(
    parameter int unsigned STEP_WIDTH = 3
) (
    input  logic [STEP_WIDTH-1:0]   step_i,
    input  logic [OPCODE_WIDTH-1:0] opcode_i,
    input  logic                    flag_carry_i,
    input  logic                    flag_zero_i,
    input  logic                    flag_negative_i,
    output control_word_t           control_word_o
);

    opcode_t op;
    logic    jump_taken;

    assign op = opcode_t'(opcode_i);

    always_comb begin
        jump_taken = 1'b0;
        case (op)
            OpJc:    jump_taken = flag_carry_i;
            OpJz:    jump_taken = flag_zero_i;
            OpJn:    jump_taken = flag_negative_i;
            default: jump_taken = 1'b0;
        endcase
    end

    always_comb begin
        control_word_o = '0;
        if (step_i == STEP_WIDTH'(0)) begin
            control_word_o.oe_pc    = 1'b1;
            control_word_o.load_mar = 1'b1;
        end else if (step_i == STEP_WIDTH'(1)) begin
            control_word_o.oe_ram  = 1'b1;
            control_word_o.load_ir = 1'b1;
            control_word_o.pc_inc  = 1'b1;
        end else if (step_i == STEP_WIDTH'(2)) begin
            case (op)
                OpLda, OpAdd, OpSub, OpSta: begin
                    control_word_o.oe_ir    = 1'b1;
                    control_word_o.load_mar = 1'b1;
                end
                OpLdi: begin
                    control_word_o.oe_ir      = 1'b1;
                    control_word_o.load_a     = 1'b1;
                    control_word_o.load_flags = 1'b1;
                    control_word_o.alu_op     = ALU_PASS;
                end
                OpJmp: begin
                    control_word_o.oe_ir   = 1'b1;
                    control_word_o.load_pc = 1'b1;
                end
                // Untaken branch leaves the T1 PC increment in place.
                OpJc, OpJz, OpJn: begin
                    control_word_o.oe_ir   = jump_taken;
                    control_word_o.load_pc = jump_taken;
                end
                OpOuta: begin
                    control_word_o.oe_a   = 1'b1;
                    control_word_o.load_o = 1'b1;
                end
                OpHlt:   control_word_o.halt = 1'b1;
                default: control_word_o = '0;
            endcase
        end else if (step_i == STEP_WIDTH'(3)) begin
            case (op)
                OpLda: begin
                    control_word_o.oe_ram = 1'b1;
                    control_word_o.load_a = 1'b1;
                end
                OpAdd, OpSub: begin
                    control_word_o.oe_ram = 1'b1;
                    control_word_o.load_b = 1'b1;
                end
                OpSta: begin
                    control_word_o.oe_a   = 1'b1;
                    control_word_o.ram_we = 1'b1;
                end
                default: control_word_o = '0;
            endcase
        end else if (step_i == STEP_WIDTH'(4)) begin
            if (op == OpAdd || op == OpSub) begin
                control_word_o.oe_alu     = 1'b1;
                control_word_o.load_a     = 1'b1;
                control_word_o.load_flags = 1'b1;
                control_word_o.alu_op     = (op == OpAdd) ? ALU_ADD : ALU_SUB;
            end
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// SAP-2 control sequencer: microstep counter, RUN/HALT state machine and reset gating
// around the combinational microcode decoder.
module control_sequencer
    import arch_defs_pkg::*;
#(
    parameter int unsigned NUM_STEPS  = 7,
    parameter int unsigned STEP_WIDTH = $clog2(NUM_STEPS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    flag_carry,
    input  logic                    flag_zero,
    input  logic                    flag_negative,
    output control_word_t           control_word,
    output logic [STEP_WIDTH-1:0]   microstep,
    output logic                    halted
);

    localparam logic [STEP_WIDTH-1:0] LastStep = STEP_WIDTH'(NUM_STEPS - 1);
    localparam logic [STEP_WIDTH-1:0] HaltStep = STEP_WIDTH'(3);

    seq_state_e              state_q, state_d;
    logic [STEP_WIDTH-1:0]   step_q, step_d;
    control_word_t           dec_word;

    control_decoder #(
        .STEP_WIDTH (STEP_WIDTH)
    ) u_decoder (
        .step_i          (step_q),
        .opcode_i        (opcode),
        .flag_carry_i    (flag_carry),
        .flag_zero_i     (flag_zero),
        .flag_negative_i (flag_negative),
        .control_word_o  (dec_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        control_word = dec_word;
        halted       = 1'b0;
        unique case (state_q)
            StRun: begin
                step_d = (step_q == LastStep) ? '0 : step_q + 1'b1;
                if (dec_word.halt) begin
                    state_d = StHalt;
                    step_d  = HaltStep;
                end
            end
            StHalt: begin
                step_d            = HaltStep;
                halted            = 1'b1;
                control_word      = '0;
                control_word.halt = 1'b1;
            end
            default: state_d = StRun;
        endcase
        // Reset must silence the bus immediately, not at the next edge.
        if (!reset) begin
            control_word = '0;
        end
    end

    assign microstep = step_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microcoded control unit for the 8-bit SAP-2 CPU. A microstep counter and a RUN/HALT state machine sequence every instruction through fetch and execute steps. Each step drives one control word to the PC, MAR, RAM, IR, A/B registers, ALU, flags and OUT register. Conditional jumps (JC/JZ/JN) are resolved here from the flag register outputs.

Parameters:
NUM_STEPS, 7, microsteps per instruction (T0..T(NUM_STEPS-1)); legal range 5..8
STEP_WIDTH, $clog2(NUM_STEPS), width of the microstep output

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
opcode  input  4  upper nibble of IR; valid from T2 onward
flag_carry  input  1  registered carry flag
flag_zero  input  1  registered zero flag
flag_negative  input  1  registered negative flag
control_word  output  control_word_t  per-step control signals
microstep  output  STEP_WIDTH  current step index
halted  output  1  CPU halted

Behaviour:
- Reset is asynchronous and active-low: step=0, state=RUN, halted=0. While reset=0, control_word is forced to all-zero combinationally. Reset dominates every other event.
- control_word is combinational from (state, step, opcode, flags), so there is zero-cycle latency within a step. Only state and step are registered.
- RUN: step increments each clk and wraps from NUM_STEPS-1 to 0. Unused steps drive an all-zero word.
- Fetch, identical for every opcode:
  - T0: oe_pc, load_mar
  - T1: oe_ram, load_ir, pc_inc
- Execute (operand = IR low nibble, zero-extended; oe_ir drives it on the bus):
  - NOP(0): none
  - LDA(1): T2 oe_ir,load_mar; T3 oe_ram,load_a
  - ADD(2): T2 oe_ir,load_mar; T3 oe_ram,load_b; T4 oe_alu,load_a,load_flags,alu_op=ALU_ADD
  - SUB(3): same as ADD with alu_op=ALU_SUB
  - STA(4): T2 oe_ir,load_mar; T3 oe_a,ram_we
  - LDI(5): T2 oe_ir,load_a,load_flags,alu_op=ALU_PASS
  - JMP(6): T2 oe_ir,load_pc
  - JC(7)/JZ(8)/JN(9): T2 oe_ir,load_pc only if flag_carry/flag_zero/flag_negative is 1 during T2; otherwise an all-zero word, and PC keeps the T1 increment.
  - OUTA(E): T2 oe_a,load_o
  - HLT(F): T2 halt=1; state→HALT at the end of T2
  - Undefined opcodes (A–D): no execute actions (behave as NOP).
- HALT: step is frozen at 3, halted=1, and control_word carries only halt=1. No load/oe/inc/we bit is ever asserted. Only reset exits HALT.
- Flags are written no later than T4 of an instruction, so they are stable at T2 of the next. No forwarding is needed.
- opcode is ignored in T0/T1.
- Reset deasserted mid-instruction: execution restarts at T0 on the first edge after release.
- At most one oe_* bit is active per step (single-driver bus). Assert this in the bench.

Decomposition:
- Shared arch_defs_pkg holds:
  - opcode_t enum (values above)
  - alu_op_t enum {ALU_PASS, ALU_ADD, ALU_SUB}
  - control_word_t packed struct: oe_pc, oe_ram, oe_ir, oe_a, oe_alu, load_mar, load_ir, load_a, load_b, load_o, load_pc, load_flags, pc_inc, ram_we, halt, alu_op
  - OPCODE_WIDTH=4
- One sub-module, control_decoder: purely combinational (step, opcode, flags) → control_word_t.
- control_sequencer itself holds the counter, the FSM and the reset gating.

Test Plan:
1. Release reset, opcode=NOP → step goes 0,1,..,6,0. T0 word = {oe_pc,load_mar} only; T1 = {oe_ram,load_ir,pc_inc} only; T2..T6 all-zero.
2. opcode=ADD(2) → T2 {oe_ir,load_mar}, T3 {oe_ram,load_b}, T4 {oe_alu,load_a,load_flags,alu_op=ALU_ADD}, T5/T6 zero.
3. opcode=JC(7), flag_carry=1 → T2 {oe_ir,load_pc}. Repeat with flag_carry=0 → T2 all-zero. Cover JZ/JN the same way with flag_zero/flag_negative.
4. opcode=HLT(F) → halted rises after the T2 edge; microstep stays 3 for 20+ cycles; control_word == halt-only.
5. Assert reset=0 at T3 of LDA → control_word is 0 immediately (same timestep). After release, step=0 and the T0 word follows.
6. Loop over all 16 opcodes × all steps × all flag combinations → at most one oe_* bit set, and undefined opcodes A–D produce zero words at T2..T6.
